// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: load-type encodings, default widths and the
// writeback skid-buffer state type.
package riscv_pkg;

  localparam int unsigned N_DEF  = 32;
  localparam int unsigned RA_DEF = 5;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } skid_state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load byte/half extraction and extension from an aligned
// memory word; flags misaligned addresses and reserved load types.
module load_align
  import riscv_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic [2:0]   ldtype,
  input  logic [1:0]   addr,
  input  logic [N-1:0] rdata,
  output logic [N-1:0] value,
  output logic         misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Reserved load types are reported through the same flag as misalignment.
  always_comb begin
    value      = '0;
    misaligned = 1'b0;
    case (ldtype)
      LD_LB:  value = {{(N-8){byte_sel[7]}}, byte_sel};
      LD_LBU: value = {{(N-8){1'b0}}, byte_sel};
      LD_LH: begin
        value      = {{(N-16){half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      LD_LHU: begin
        value      = {{(N-16){1'b0}}, half_sel};
        misaligned = addr[0];
      end
      LD_LW: begin
        value      = rdata;
        misaligned = (addr != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Writeback stage: selects ALU/load data, arbitrates the register-file write
// port between MEM and the mul/div unit through a one-entry skid buffer.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned RA = RA_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [RA-1:0] mem_rd,
  input  logic          mem_regwrite,
  input  logic          mem_memtoreg,
  input  logic [2:0]    mem_ldtype,
  input  logic [N-1:0]  mem_alu_result,
  input  logic [N-1:0]  mem_rdata,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [RA-1:0] md_rd,
  input  logic [N-1:0]  md_result,
  output logic [RA-1:0] writereg,
  output logic [N-1:0]  data,
  output logic          rw,
  output logic          fwd_en,
  output logic [RA-1:0] fwd_rd,
  output logic [N-1:0]  fwd_data,
  output logic          misalign_err
);

  skid_state_t   state;
  logic [RA-1:0] held_rd;
  logic [N-1:0]  held_data;

  logic [N-1:0]  load_value;
  logic          load_bad;
  logic [N-1:0]  mem_value;
  logic          mem_acc;
  logic          md_acc;
  logic          mem_err;

  load_align #(.N(N)) u_load_align (
    .ldtype     (mem_ldtype),
    .addr       (mem_alu_result[1:0]),
    .rdata      (mem_rdata),
    .value      (load_value),
    .misaligned (load_bad)
  );

  always_comb begin
    mem_ready = (state == EMPTY);
    md_ready  = (state == EMPTY);
    mem_acc   = mem_valid && mem_ready;
    md_acc    = md_valid && md_ready;
    mem_value = mem_memtoreg ? load_value : mem_alu_result;
    mem_err   = mem_memtoreg && load_bad;
  end

  // MEM wins the port on a simultaneous accept; md parks in the buffer and
  // the buffer drains unconditionally on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      held_rd      <= '0;
      held_data    <= '0;
      writereg     <= '0;
      data         <= '0;
      rw           <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (mem_acc) begin
            writereg     <= mem_rd;
            data         <= mem_value;
            rw           <= mem_regwrite && !mem_err && (mem_rd != '0);
            misalign_err <= mem_err;
            if (md_acc) begin
              held_rd   <= md_rd;
              held_data <= md_result;
              state     <= HELD;
            end
          end else if (md_acc) begin
            writereg     <= md_rd;
            data         <= md_result;
            rw           <= (md_rd != '0);
            misalign_err <= 1'b0;
          end else begin
            rw           <= 1'b0;
            misalign_err <= 1'b0;
          end
        end
        HELD: begin
          writereg     <= held_rd;
          data         <= held_data;
          rw           <= (held_rd != '0);
          misalign_err <= 1'b0;
          state        <= EMPTY;
        end
        default: begin
          rw           <= 1'b0;
          misalign_err <= 1'b0;
          state        <= EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    fwd_en   = rw;
    fwd_rd   = writereg;
    fwd_data = data;
  end

endmodule
